// File: rtl/cnn_layer_if.sv
// cnn_layer_if: port bundle between the feeder and the CNN layer datapath
interface cnn_layer_if #(parameter int INPUT = 4, FILTER = 4, RESULT = 10);
   logic                     Start;
   logic [INPUT-1:0]         Image;
   logic signed [FILTER-1:0] Filter;
   logic                     ReadEn;
   logic signed [RESULT-1:0] ConvResult;
   modport master (output Start, Image, Filter, ReadEn, input ConvResult);
   modport slave (input Start, Image, Filter, ReadEn, output ConvResult);
endinterface

// File: rtl/cnn_layer_feeder.sv
// cnn_layer_feeder: sequences one 1-D convolution pass through the layer and collects its results.
// Optional CNN_FEEDER_MAX_EN: running signed maximum of the pass on res_max.
module cnn_layer_feeder #(
   parameter int INPUT  = 4,
   parameter int FILTER = 4,
   parameter int RESULT = 10,
   parameter int OUTNUM = 5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     pix_we,
   input  logic [2:0]               pix_addr,
   input  logic [INPUT-1:0]         pix_data,
   input  logic                     flt_we,
   input  logic [1:0]               flt_addr,
   input  logic signed [FILTER-1:0] flt_data,
   input  logic                     go,
   output logic                     busy,
   output logic                     done,
   cnn_layer_if.master              lay,
   output logic                     res_valid,
   output logic [2:0]               res_idx,
   output logic signed [RESULT-1:0] res_data,
   output logic signed [RESULT-1:0] res_max
);
   typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
   localparam logic [4:0] W_LAST = 5'(3 * OUTNUM - 1);
   localparam logic [4:0] R_LAST = 5'(OUTNUM - 1);
   state_t                   state, state_nxt;
   logic [4:0]               cnt, cnt_nxt, k_tap, k_idx;
   logic [INPUT-1:0]         pix [OUTNUM+2];
   logic signed [FILTER-1:0] flt [3];
   logic                     rd_d, start_n, read_n;
   logic [INPUT-1:0]         image_n;
   logic signed [FILTER-1:0] filter_n;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   always_comb begin
      state_nxt = state == IDLE  ? (go ? WRITE : IDLE) :
                  state == WRITE ? (cnt == W_LAST ? READ : WRITE) :
                  state == READ  ? (cnt == R_LAST ? DRAIN : READ) :
                  state == DRAIN ? (cnt == 5'd1 ? DONE : DRAIN) : IDLE;
      cnt_nxt   = (state_nxt != state || state_nxt == IDLE) ? '0 : cnt + 5'd1;
   end
   // product k pairs pixel k/3 + k%3 with tap k%3, matching the layer's address order
   always_comb begin
      k_tap    = cnt_nxt % 5'd3;
      k_idx    = cnt_nxt / 5'd3 + k_tap;
      start_n  = state_nxt == WRITE;
      read_n   = state_nxt == READ;
      image_n  = start_n ? pix[k_idx[2:0]] : '0;
      filter_n = start_n ? flt[k_tap[1:0]] : '0;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         lay.Start  <= 1'b0;
         lay.Image  <= '0;
         lay.Filter <= '0;
         lay.ReadEn <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         rd_d       <= 1'b0;
         res_valid  <= 1'b0;
         res_idx    <= '0;
         res_data   <= '0;
      end else begin
         lay.Start  <= start_n;
         lay.Image  <= image_n;
         lay.Filter <= filter_n;
         lay.ReadEn <= read_n;
         busy       <= state_nxt != IDLE;
         done       <= state_nxt == DONE;
         rd_d       <= lay.ReadEn;
         res_valid  <= rd_d;
         res_idx    <= rd_d ? (res_valid ? res_idx + 3'd1 : 3'd0) : 3'd0;
         res_data   <= rd_d ? lay.ConvResult : '0;
      end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < OUTNUM + 2; i++) pix[i] <= '0;
         for (int i = 0; i < 3; i++) flt[i] <= '0;
      end else if (state == IDLE) begin
         if (pix_we && 32'(pix_addr) < OUTNUM + 2) pix[pix_addr] <= pix_data;
         if (flt_we && flt_addr != 2'd3) flt[flt_addr] <= flt_data;
      end
`ifdef CNN_FEEDER_MAX_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) res_max <= '0;
      else if (state == IDLE && go) res_max <= '0;
      else if (rd_d && lay.ConvResult > res_max) res_max <= lay.ConvResult;
`else
   assign res_max = '0;
`endif
endmodule

// File: tb/tb_cnn_layer_feeder.sv
// tb_cnn_layer_feeder: directed passes against a behavioural model of the layer datapath.
module tb_cnn_layer_feeder;
   logic              clk = 1'b0, rst_n = 1'b0;
   logic              pix_we = 1'b0, flt_we = 1'b0, go = 1'b0;
   logic [2:0]        pix_addr = '0;
   logic [3:0]        pix_data = '0;
   logic [1:0]        flt_addr = '0;
   logic signed [3:0] flt_data = '0;
   logic              busy, done, res_valid;
   logic [2:0]        res_idx;
   logic signed [9:0] res_data, res_max;
   int checks = 0, errors = 0;
   int pix_m [7];
   int flt_m [3];
   int exp_res [5];
   int exp_max;
   int mem [15];
   int wa, ra;
   always #5 clk = ~clk;
   cnn_layer_if #(.INPUT(4), .FILTER(4), .RESULT(10)) lif ();
   cnn_layer_feeder dut (
      .clk(clk), .rst_n(rst_n),
      .pix_we(pix_we), .pix_addr(pix_addr), .pix_data(pix_data),
      .flt_we(flt_we), .flt_addr(flt_addr), .flt_data(flt_data),
      .go(go), .busy(busy), .done(done), .lay(lif.master),
      .res_valid(res_valid), .res_idx(res_idx), .res_data(res_data), .res_max(res_max)
   );
   function automatic logic signed [9:0] relu_sum(input int r);
      int s;
      s = mem[3*r] + mem[3*r+1] + mem[3*r+2];
      return s < 0 ? 10'sd0 : 10'(s);
   endfunction
   // layer model: stores product k at address k, registered ReLU'd sums on ReadEn
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wa <= 0;
         ra <= 0;
         lif.ConvResult <= '0;
      end else begin
         if (lif.Start) begin
            mem[wa] <= int'(lif.Image) * int'(lif.Filter);
            wa <= wa == 14 ? 0 : wa + 1;
         end
         if (lif.ReadEn) begin
            lif.ConvResult <= relu_sum(ra);
            ra <= ra == 4 ? 0 : ra + 1;
         end
      end
   task automatic chk(input string tag, input int obs, input int exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, obs, exp_v);
      end
   endtask
   task automatic load();
      for (int i = 0; i < 7; i++) begin
         @(posedge clk); #1;
         pix_we = 1'b1; pix_addr = 3'(i); pix_data = 4'(pix_m[i]);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         pix_we = 1'b0; flt_we = 1'b1; flt_addr = 2'(i); flt_data = 4'(flt_m[i]);
      end
      @(posedge clk); #1;
      flt_we = 1'b0;
   endtask
   task automatic run_pass(input bit inject);
      int ns = 0, nr = 0, nv = 0, nd = 0, fs = 0, fr = 0, fv = 0, fd = 0;
      @(posedge clk); #1 go = 1'b1;
      @(posedge clk); #1 go = 1'b0;
      for (int c = 1; c <= 24; c++) begin
         @(negedge clk);
         if (lif.Start) begin
            ns++;
            if (ns == 1) fs = c;
            if (c <= 15) begin
               chk("image", int'(lif.Image), pix_m[(c-1)/3 + (c-1)%3]);
               chk("filter", int'(lif.Filter), flt_m[(c-1)%3]);
            end
         end
         if (lif.ReadEn) begin
            nr++;
            if (nr == 1) fr = c;
         end
         if (res_valid) begin
            nv++;
            if (nv == 1) fv = c;
            if (nv <= 5) begin
               chk("res_idx", int'(res_idx), nv - 1);
               chk("res_data", int'(res_data), exp_res[nv-1]);
            end
         end
         if (done) begin
            nd++;
            fd = c;
         end
         if (c == 1) chk("busy_c1", int'(busy), 1);
         if (c == 24) chk("busy_idle", int'(busy), 0);
         go = inject && (c == 5 || c == 23);
         pix_we = inject && c == 10;
         pix_addr = 3'd0;
         pix_data = 4'd9;
      end
      go = 1'b0;
      pix_we = 1'b0;
      chk("start_cnt", ns, 15);
      chk("start_first", fs, 1);
      chk("read_cnt", nr, 5);
      chk("read_first", fr, 16);
      chk("valid_cnt", nv, 5);
      chk("valid_first", fv, 18);
      chk("done_cnt", nd, 1);
      chk("done_cycle", fd, 23);
`ifdef CNN_FEEDER_MAX_EN
      chk("res_max", int'(res_max), exp_max);
`else
      chk("res_max", int'(res_max), 0);
`endif
   endtask
   task automatic set_case(input int p0, input int pstep, input int t0, input int t1, input int t2,
                           input int r, input int mx);
      for (int i = 0; i < 7; i++) pix_m[i] = p0 + pstep * i;
      flt_m[0] = t0; flt_m[1] = t1; flt_m[2] = t2;
      for (int j = 0; j < 5; j++) exp_res[j] = r;
      exp_max = mx;
   endtask
   initial begin
      #12;
      chk("rst_start", int'(lif.Start), 0);
      chk("rst_readen", int'(lif.ReadEn), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_valid", int'(res_valid), 0);
      chk("rst_data", int'(res_data), 0);
      @(negedge clk) rst_n = 1'b1;
      set_case(1, 1, 1, 1, 1, 0, 18);
      exp_res[0] = 6; exp_res[1] = 9; exp_res[2] = 12; exp_res[3] = 15; exp_res[4] = 18;
      load();
      run_pass(1'b0);
      set_case(1, 1, 1, 0, -1, 0, 0);
      load();
      run_pass(1'b0);
      set_case(15, 0, 7, 7, 7, 315, 315);
      load();
      run_pass(1'b0);
      set_case(15, 0, -8, -8, -8, 0, 0);
      load();
      run_pass(1'b0);
      set_case(1, 1, 1, 1, 1, 0, 18);
      exp_res[0] = 6; exp_res[1] = 9; exp_res[2] = 12; exp_res[3] = 15; exp_res[4] = 18;
      load();
      run_pass(1'b1);
      run_pass(1'b0);
      @(posedge clk); #1 go = 1'b1;
      @(posedge clk); #1 go = 1'b0;
      for (int c = 1; c <= 8; c++) @(negedge clk);
      chk("pre_rst_start", int'(lif.Start), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_start", int'(lif.Start), 0);
      chk("abort_image", int'(lif.Image), 0);
      chk("abort_filter", int'(lif.Filter), 0);
      chk("abort_busy", int'(busy), 0);
      @(negedge clk) rst_n = 1'b1;
      set_case(0, 0, 0, 0, 0, 0, 0);
      run_pass(1'b0);
      set_case(1, 1, 1, 1, 1, 0, 18);
      exp_res[0] = 6; exp_res[1] = 9; exp_res[2] = 12; exp_res[3] = 15; exp_res[4] = 18;
      load();
      run_pass(1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cnn_layer_feeder.md
# cnn_layer_feeder

Sequencer that drives one single-layer 1-D convolution pass through the CNN layer datapath and collects its results. It holds a 7-pixel image line and 3 filter taps, streams the 15 image×filter products with the write strobe in the layer's address order, then issues the read strobes and captures the 5 ReLU'd convolution outputs. It sits between the host/test harness and the layer's `Start`/`Image`/`Filter`/`ReadEn`/`ConvResult` ports.

## Interface
- INPUT, 4, image pixel width (unsigned)
- FILTER, 4, filter tap width (signed)
- RESULT, 10, convolution result width (signed)
- OUTNUM, 5, outputs per pass; taps fixed at 3, pixels = OUTNUM+2, products = 3·OUTNUM
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pix_we  in  1  pixel buffer write strobe
- pix_addr  in  3  pixel index 0..OUTNUM+1
- pix_data  in  INPUT  pixel value
- flt_we  in  1  tap buffer write strobe
- flt_addr  in  2  tap index 0..2
- flt_data  in  FILTER  tap value (signed)
- go  in  1  start one pass (sampled in IDLE only)
- busy  out  1  high from cycle after accepted go until done
- done  out  1  one-cycle pulse at pass end
- Start  out  1  layer write strobe
- Image  out  INPUT  pixel to layer multiplier
- Filter  out  FILTER  tap to layer multiplier
- ReadEn  out  1  layer read strobe
- ConvResult  in  RESULT  layer output (registered in layer)
- res_valid  out  1  result strobe
- res_idx  out  3  result index 0..OUTNUM-1
- res_data  out  RESULT  captured result
- res_max  out  RESULT  maximum of the pass's results (see Configuration)

## Operation
- States: IDLE → WRITE (3·OUTNUM cycles) → READ (OUTNUM cycles) → DRAIN (2 cycles) → DONE (1 cycle) → IDLE.
- All outputs registered. Reset: state IDLE, all outputs 0, pixel/tap buffers 0, counters 0.
- IDLE: go=1 → WRITE next cycle; buffer writes accepted only in IDLE, ignored otherwise. Out-of-range addresses ignored.
- WRITE, product k=0..14: Start=1, Image=pix[k/3 + k%3], Filter=flt[k%3]; layer stores product k at address k, so output j sums addresses 3j..3j+2. Start stays high contiguously for exactly 15 cycles; the layer's address counter must reach 15 writes with no gap.
- READ: ReadEn=1 for exactly OUTNUM contiguous cycles; Start=0, Image/Filter=0 outside WRITE.
- Capture: ConvResult of read j is valid one cycle after ReadEn cycle j; feeder registers it, so res_valid=1 with res_idx=j, res_data=ConvResult two cycles after ReadEn cycle j. DRAIN covers the pipeline tail.
- DONE: done=1, busy=0 next cycle. go during busy ignored; go in the DONE cycle ignored.
- rst_n low mid-pass: immediate abort, all outputs 0; layer must be reset with the same rst_n.

## Timing
- go sampled at edge E0 → busy, Start high in cycles 1..15, ReadEn high in 16..20, res_valid high in 18..22, done in 23, back in IDLE at 24. Pass latency 23 cycles from go to done for OUTNUM=5.
- One result per cycle, no backpressure; consumer must accept every res_valid.

## Configuration
- CNN_FEEDER_MAX_EN defined: res_max is a running signed maximum, cleared to 0 on accepted go, updated on each res_valid; holds the final max from the done cycle until the next go.
- Undefined: res_max tied to 0, no comparator logic.

## Test plan
- Pixels 1..7, taps (1,1,1), go → Image/Filter sequence matches pix[k/3+k%3]/flt[k%3] for k=0..14; res_data 6,9,12,15,18 at idx 0..4; res_max=18 with CNN_FEEDER_MAX_EN.
- Pixels 1..7, taps (1,0,-1) → all sums −2, ReLU gives res_data 0 ×5; res_max=0.
- All pixels 15, taps (7,7,7) → res_data 315 ×5 (no overflow); all pixels 15, taps (−8,−8,−8) → 0 ×5.
- go pulsed again in cycles 5 and 23, pix_we in cycle 10 → ignored; second pass gives identical results.
- rst_n low in cycle 8 of WRITE → all outputs 0 asynchronously, state IDLE, buffers 0; fresh load plus go gives correct results.
- Cycle-count check: Start high exactly 15 cycles, ReadEn exactly 5, done single pulse at cycle 23, busy low in IDLE.
